adder_tree_layer: RTL and testbench
===================================

Name: adder_tree_layer

Overview:
- One reduction layer of a signed adder tree.
- Takes INPUTS_AMOUNT two's-complement operands of DATAW bits and outputs INPUTS_AMOUNT/2 pairwise sums of DATAW+1 bits: output i = input 2i + input 2i+1.
- Cascading instances, each with DATAW increased by one, forms a full adder tree.
- Default build is purely combinational; an optional output register stage uses the clock and reset.

Parameters:
- INPUTS_AMOUNT, 8, number of input operands; must be even and ≥2.
- DATAW, 8, width of each input operand in bits (signed two's complement); must be ≥1.

Ports:
- clk_i  input  1  clock; used only when the register stage is compiled in.
- rst_i  input  1  reset, synchronous, active-high.
- valid_i  input  1  input operands are valid this cycle.
- inputs  input  unpacked array [INPUTS_AMOUNT] of [DATAW-1:0]  operands, interpreted as signed.
- outputs  output  unpacked array [INPUTS_AMOUNT/2] of [DATAW:0]  pairwise signed sums.
- valid_o  output  1  outputs are valid.

Behaviour:
- Elaboration check:
  - INPUTS_AMOUNT odd or <2 → $fatal/$error at elaboration.
  - DATAW <1 → $fatal/$error at elaboration.
- Arithmetic, for each i in 0..INPUTS_AMOUNT/2-1:
  - outputs[i] = sext(inputs[2i]) + sext(inputs[2i+1]), each operand sign-extended to DATAW+1 bits before the add.
  - Result is exact; overflow is impossible.
  - Range: -2^DATAW .. 2^DATAW-2 (DATAW=8: -256..254).
  - No saturation, no rounding, no truncation.
  - Pairing is strictly adjacent: index 2i with 2i+1. No cross-pair mixing.
- Default build (macro undefined):
  - outputs and valid_o are combinational functions of inputs and valid_i; zero latency.
  - outputs settle within the same delta/time step as an input change.
  - outputs are computed regardless of valid_i; valid_o = valid_i.
  - clk_i and rst_i have no effect.
- X/Z on any bit of a pair's inputs may corrupt that pair's output only. Other pairs are unaffected.
- No internal state in the default build, hence no reset value.

Optional Feature:
- Macro: ADDER_TREE_LAYER_REG_EN.
- When defined, an output register stage is inserted.
  - On each rising clk_i edge:
    - rst_i=1 → all outputs[i] <= 0, valid_o <= 0.
    - else if valid_i=1 → outputs <= pairwise sums, valid_o <= 1.
    - else → outputs hold previous value, valid_o <= 0.
  - Latency is exactly 1 cycle; throughput 1 result per cycle.
  - Reset takes priority over valid_i in the same cycle.
  - Reset asserted mid-stream clears any in-flight result; the first valid result after reset deasserts appears one cycle after the first valid_i=1.
- When undefined: combinational behaviour as in Behaviour.

Test Plan (INPUTS_AMOUNT=8, DATAW=8; in the registered build, check one cycle after valid_i):
- All zeros: all inputs 0, valid_i=1 → all four outputs 9'h000, valid_o=1.
- Directed corners: inputs {10,-3, 127,1, -128,-1, 50,-50} → outputs {7, 128 (9'h080), -129 (9'h17F), 0}.
- Extremes: inputs {127,127, -128,-128, -1,-1, 127,-128} → outputs {254 (9'h0FE), -256 (9'h100), -2 (9'h1FE), -1 (9'h1FF)}.
- Randomised, at least 50 vectors: uniform random 8-bit patterns → every output === $signed(a)+$signed(b) computed at 9 bits; abort on first mismatch with pair index.
- Registered build, reset: load {127,1,...} with valid_i=1, then assert rst_i together with valid_i=1 for one cycle → after that edge all outputs 0 and valid_o=0; deassert rst_i → result appears one edge later.
- Registered build, hold: valid_i=0 while inputs change → outputs unchanged, valid_o=0.

Source files
------------

// File: rtl/adder_tree_layer.sv
// One reduction layer of a signed adder tree: outputs[i] = inputs[2i] + inputs[2i+1], one bit wider.
// Define ADDER_TREE_LAYER_REG_EN to add a one-cycle output register stage (sync active-high reset).
module adder_tree_layer #(
  parameter int unsigned INPUTS_AMOUNT = 8,
  parameter int unsigned DATAW         = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  input  logic [DATAW-1:0] inputs  [INPUTS_AMOUNT],
  output logic [DATAW:0]   outputs [INPUTS_AMOUNT/2],
  output logic             valid_o
);

  localparam int unsigned OUTPUTS_AMOUNT = INPUTS_AMOUNT / 2;
  localparam int unsigned SUMW           = DATAW + 1;

  if ((INPUTS_AMOUNT < 2) || ((INPUTS_AMOUNT % 2) != 0)) begin : g_bad_inputs_amount
    $fatal(1, "adder_tree_layer: INPUTS_AMOUNT must be even and >= 2");
  end

  if (DATAW < 1) begin : g_bad_dataw
    $fatal(1, "adder_tree_layer: DATAW must be >= 1");
  end

  logic [SUMW-1:0] sum_c [OUTPUTS_AMOUNT];

  // Each pair is sign-extended by one bit before the add, so the sum is exact.
  for (genvar i = 0; i < OUTPUTS_AMOUNT; i++) begin : g_pair
    logic [SUMW-1:0] a_ext;
    logic [SUMW-1:0] b_ext;
    assign a_ext    = {inputs[2*i][DATAW-1],   inputs[2*i]};
    assign b_ext    = {inputs[2*i+1][DATAW-1], inputs[2*i+1]};
    assign sum_c[i] = a_ext + b_ext;
  end

`ifdef ADDER_TREE_LAYER_REG_EN
  // Output register: reset clears, valid loads, otherwise data holds and valid drops.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < OUTPUTS_AMOUNT; i++) begin
        outputs[i] <= '0;
      end
      valid_o <= 1'b0;
    end else begin
      valid_o <= valid_i;
      if (valid_i) begin
        outputs <= sum_c;
      end
    end
  end
`else
  // Clock and reset are part of the interface only so layers stay pin-compatible.
  logic unused_clk_rst;
  assign unused_clk_rst = clk_i ^ rst_i;

  assign outputs = sum_c;
  assign valid_o = valid_i;
`endif

endmodule

// File: tb/tb_adder_tree_layer.sv
// Directed + random checks for adder_tree_layer (INPUTS_AMOUNT=8, DATAW=8).
// Follows ADDER_TREE_LAYER_REG_EN to match the combinational or registered build.
module tb_adder_tree_layer;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       valid_i;
  logic [7:0] inputs  [8];
  logic [8:0] outputs [4];
  logic       valid_o;

  logic [7:0] stim [8];
  logic [8:0] expv [4];
  int         checks   = 0;
  int         failures = 0;

  adder_tree_layer #(.INPUTS_AMOUNT(8), .DATAW(8)) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .valid_i (valid_i),
    .inputs  (inputs),
    .outputs (outputs),
    .valid_o (valid_o)
  );

  always #5 clk_i = ~clk_i;

  // Apply stim with the given valid and return at the point the result is observable.
  task automatic drive(input logic v);
    valid_i = v;
    inputs  = stim;
`ifdef ADDER_TREE_LAYER_REG_EN
    @(posedge clk_i);
    #1;
`else
    #1;
`endif
  endtask

  task automatic test_reset;
    rst_i = 1'b1;
    stim  = '{8'h0A, 8'hFD, 8'h7F, 8'h01, 8'h80, 8'hFF, 8'h32, 8'hCE};
`ifdef ADDER_TREE_LAYER_REG_EN
    expv  = '{9'h000, 9'h000, 9'h000, 9'h000};
    drive(1'b1);
    drive(1'b1);
    checks++;
    if (valid_o !== 1'b0) begin
      failures++;
      $display("FAIL reset valid_o got %b want 0", valid_o);
    end
`else
    // Reset has no effect in the combinational build.
    expv  = '{9'h007, 9'h080, 9'h17F, 9'h000};
    drive(1'b1);
    checks++;
    if (valid_o !== 1'b1) begin
      failures++;
      $display("FAIL reset valid_o got %b want 1", valid_o);
    end
`endif
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (outputs[i] !== expv[i]) begin
        failures++;
        $display("FAIL reset out[%0d] got %h want %h", i, outputs[i], expv[i]);
      end
    end
    rst_i = 1'b0;
  endtask

  task automatic test_zeros;
    stim = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    expv = '{9'h000, 9'h000, 9'h000, 9'h000};
    drive(1'b1);
    checks++;
    if (valid_o !== 1'b1) begin
      failures++;
      $display("FAIL zeros valid_o got %b want 1", valid_o);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (outputs[i] !== expv[i]) begin
        failures++;
        $display("FAIL zeros out[%0d] got %h want %h", i, outputs[i], expv[i]);
      end
    end
  endtask

  task automatic test_corners;
    stim = '{8'h0A, 8'hFD, 8'h7F, 8'h01, 8'h80, 8'hFF, 8'h32, 8'hCE};
    expv = '{9'h007, 9'h080, 9'h17F, 9'h000};
    drive(1'b1);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (outputs[i] !== expv[i]) begin
        failures++;
        $display("FAIL corners out[%0d] got %h want %h", i, outputs[i], expv[i]);
      end
    end
  endtask

  task automatic test_extremes;
    stim = '{8'h7F, 8'h7F, 8'h80, 8'h80, 8'hFF, 8'hFF, 8'h7F, 8'h80};
    expv = '{9'h0FE, 9'h100, 9'h1FE, 9'h1FF};
    drive(1'b1);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (outputs[i] !== expv[i]) begin
        failures++;
        $display("FAIL extremes out[%0d] got %h want %h", i, outputs[i], expv[i]);
      end
    end
  endtask

  // Valid is forwarded; in the combinational build data is still computed without it.
  task automatic test_valid_low;
    stim = '{8'h01, 8'h02, 8'h03, 8'h04, 8'hFF, 8'h01, 8'h80, 8'h7F};
    drive(1'b0);
    checks++;
    if (valid_o !== 1'b0) begin
      failures++;
      $display("FAIL valid_low valid_o got %b want 0", valid_o);
    end
`ifndef ADDER_TREE_LAYER_REG_EN
    expv = '{9'h003, 9'h007, 9'h000, 9'h1FF};
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (outputs[i] !== expv[i]) begin
        failures++;
        $display("FAIL valid_low out[%0d] got %h want %h", i, outputs[i], expv[i]);
      end
    end
`endif
  endtask

  task automatic test_x_isolation;
    stim = '{8'hxx, 8'h05, 8'h10, 8'h20, 8'hF0, 8'h0F, 8'h81, 8'hFF};
    expv = '{9'h000, 9'h030, 9'h1FF, 9'h180};
    drive(1'b1);
    for (int i = 1; i < 4; i++) begin
      checks++;
      if (outputs[i] !== expv[i]) begin
        failures++;
        $display("FAIL x_isolation out[%0d] got %h want %h", i, outputs[i], expv[i]);
      end
    end
  endtask

  task automatic test_random;
    int sum;
    bit bad = 1'b0;
    for (int n = 0; n < 60 && !bad; n++) begin
      for (int k = 0; k < 8; k++) stim[k] = 8'($urandom_range(0, 255));
      for (int k = 0; k < 4; k++) begin
        sum     = int'($signed(stim[2*k])) + int'($signed(stim[2*k+1]));
        expv[k] = sum[8:0];
      end
      drive(1'b1);
      for (int i = 0; i < 4 && !bad; i++) begin
        checks++;
        if (outputs[i] !== expv[i]) begin
          failures++;
          bad = 1'b1;
          $display("FAIL random vec %0d pair %0d got %h want %h", n, i, outputs[i], expv[i]);
        end
      end
    end
  endtask

`ifdef ADDER_TREE_LAYER_REG_EN
  task automatic test_hold;
    stim = '{8'h7F, 8'h01, 8'h40, 8'h40, 8'hC0, 8'hC0, 8'h05, 8'hFB};
    expv = '{9'h080, 9'h080, 9'h180, 9'h000};
    drive(1'b1);
    stim = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h11};
    drive(1'b0);
    stim = '{8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01};
    drive(1'b0);
    checks++;
    if (valid_o !== 1'b0) begin
      failures++;
      $display("FAIL hold valid_o got %b want 0", valid_o);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (outputs[i] !== expv[i]) begin
        failures++;
        $display("FAIL hold out[%0d] got %h want %h", i, outputs[i], expv[i]);
      end
    end
  endtask

  task automatic test_reset_midstream;
    stim = '{8'h7F, 8'h01, 8'h7F, 8'h01, 8'h7F, 8'h01, 8'h7F, 8'h01};
    drive(1'b1);
    checks++;
    if (outputs[0] !== 9'h080 || valid_o !== 1'b1) begin
      failures++;
      $display("FAIL rst_mid preload got %h/%b want 080/1", outputs[0], valid_o);
    end
    rst_i = 1'b1;
    drive(1'b1);
    checks++;
    if (valid_o !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid valid_o got %b want 0", valid_o);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (outputs[i] !== 9'h000) begin
        failures++;
        $display("FAIL rst_mid out[%0d] got %h want 000", i, outputs[i]);
      end
    end
    rst_i = 1'b0;
    drive(1'b1);
    checks++;
    if (valid_o !== 1'b1) begin
      failures++;
      $display("FAIL rst_mid resume valid_o got %b want 1", valid_o);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (outputs[i] !== 9'h080) begin
        failures++;
        $display("FAIL rst_mid resume out[%0d] got %h want 080", i, outputs[i]);
      end
    end
  endtask

  task automatic test_back_to_back;
    stim = '{8'h01, 8'h01, 8'h02, 8'h02, 8'h03, 8'h03, 8'h04, 8'h04};
    drive(1'b1);
    checks++;
    if (outputs[3] !== 9'h008 || valid_o !== 1'b1) begin
      failures++;
      $display("FAIL b2b first got %h/%b want 008/1", outputs[3], valid_o);
    end
    stim = '{8'hFF, 8'hFE, 8'h00, 8'h00, 8'h80, 8'h00, 8'h7F, 8'h00};
    drive(1'b1);
    expv = '{9'h1FD, 9'h000, 9'h180, 9'h07F};
    checks++;
    if (valid_o !== 1'b1) begin
      failures++;
      $display("FAIL b2b second valid_o got %b want 1", valid_o);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (outputs[i] !== expv[i]) begin
        failures++;
        $display("FAIL b2b second out[%0d] got %h want %h", i, outputs[i], expv[i]);
      end
    end
  endtask
`endif

  initial begin
    #1_000_000;
    $display("FAIL timeout simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    rst_i   = 1'b0;
    valid_i = 1'b0;
    stim    = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    inputs  = stim;
    #2;
    test_reset();
    test_zeros();
    test_corners();
    test_extremes();
    test_valid_low();
    test_x_isolation();
`ifdef ADDER_TREE_LAYER_REG_EN
    test_hold();
    test_reset_midstream();
    test_back_to_back();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
